// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer and related input-conditioning
// stages: FSM state encodings and the default qualification length.
package debounce_pkg;

    // Debouncer FSM states: STABLE while dout matches the input, COUNT while
    // a candidate new level is being qualified.
    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_t;

    // Default number of consecutive synchronized samples needed to accept a
    // new level.
    localparam int DEFAULT_STABLE_CYCLES = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Reusable by any stage that samples an external, unclocked signal.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Switch/button debouncer: synchronizes a raw level, then accepts a new level
// only after STABLE_CYCLES consecutive synchronized samples disagree with the
// current output. A shorter mismatch is rejected as a glitch.
// Optional build macro SWITCH_DEBOUNCER_EDGE_PULSE_EN enables the registered
// rise/fall pulses; without it rise and fall are constant 0.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             din_s;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             dout_q, dout_n;
    logic             accept;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (din_s)
    );

    // State, mismatch counter and debounced output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_STABLE;
            cnt    <= '0;
            dout_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            dout_q <= dout_n;
        end
    end

    // Next-state logic: count consecutive mismatching samples, drop back on
    // any agreeing sample, accept the new level on the last counted sample.
    // cnt stops at STABLE_CYCLES-1 and is cleared on acceptance, so it never wraps.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dout_n  = dout_q;
        accept  = 1'b0;
        case (state)
            ST_STABLE: begin
                cnt_n = '0;
                if (din_s != dout_q) begin
                    state_n = ST_COUNT;
                    cnt_n   = CNT_ONE;
                end
            end
            ST_COUNT: begin
                if (din_s == dout_q) begin
                    state_n = ST_STABLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = ST_STABLE;
                    cnt_n   = '0;
                    dout_n  = din_s;
                    accept  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = ST_STABLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign dout = dout_q;
    assign busy = (state == ST_COUNT);

`ifdef SWITCH_DEBOUNCER_EDGE_PULSE_EN
    logic rise_q, fall_q;

    // Edge pulses registered on the same edge that updates dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept & din_s;
            fall_q <= accept & ~din_s;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    // Edge pulses disabled: ports kept, driven constant.
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with STABLE_CYCLES = 4 and a
// 20 ns clock. A reference model built from the debouncing rules (a run
// length of consecutive disagreeing samples seen two edges late) is compared
// against the DUT after every rising edge; directed scenarios add explicit
// edge-count checks, followed by a randomized run.
module tb_switch_debouncer;

    localparam int N = 4;
`ifdef SWITCH_DEBOUNCER_EDGE_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic dout, rise, fall, busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic sq[$];
    logic dout_m, rise_m, fall_m, busy_m;
    int   run;

    // observation counters
    int   rise_cnt, fall_cnt, dout_changes, busy_seen;
    logic dout_prev;

    switch_debouncer #(.STABLE_CYCLES(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    // clock
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        sq.push_back(1'b0);
        sq.push_back(1'b0);
        dout_m = 1'b0; rise_m = 1'b0; fall_m = 1'b0; busy_m = 1'b0;
        run = 0;
    endtask

    task automatic clear_obs();
        rise_cnt = 0; fall_cnt = 0; dout_changes = 0; busy_seen = 0;
        dout_prev = dout;
    endtask

    // One clock: drive din (called at negedge), update model at the edge,
    // compare #1 later, return at the next negedge.
    task automatic cycle(input logic d);
        logic s;
        din = d;
        @(posedge clk);
        s = sq[0];
        void'(sq.pop_front());
        sq.push_back(din);
        rise_m = 1'b0;
        fall_m = 1'b0;
        if (s != dout_m) begin
            run++;
            if (run == N) begin
                dout_m = s;
                run = 0;
                rise_m = PULSE & s;
                fall_m = PULSE & ~s;
            end
        end else begin
            run = 0;
        end
        busy_m = (run != 0);
        #1;
        chk("dout", dout, dout_m);
        chk("busy", busy, busy_m);
        chk("rise", rise, rise_m);
        chk("fall", fall, fall_m);
        if (rise === 1'b1) rise_cnt++;
        if (fall === 1'b1) fall_cnt++;
        if (busy === 1'b1) busy_seen++;
        if (dout !== dout_prev) dout_changes++;
        dout_prev = dout;
        @(negedge clk);
    endtask

    // Assert reset at a negedge, check outputs clear without a clock edge.
    task automatic apply_reset(input logic d, input int hold);
        din = d;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_dout", dout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rise", rise, 1'b0);
        chk("rst_fall", fall, 1'b0);
        repeat (hold) @(negedge clk);
        chk("rst_hold_dout", dout, 1'b0);
        chk("rst_hold_busy", busy, 1'b0);
        rst = 1'b0;
        clear_obs();
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Scenario 1: din = 1 during reset, dout rises on 6th edge after release
        apply_reset(1'b1, 3);
        for (int k = 1; k <= 7; k++) begin
            cycle(1'b1);
            if (k == 5) chk("s1_dout_e5", dout, 1'b0);
            if (k == 6) begin
                chk("s1_dout_e6", dout, 1'b1);
                chk("s1_rise_e6", rise, PULSE);
            end
            if (k == 7) chk("s1_rise_e7", rise, 1'b0);
        end
        chk_int("s1_rise_cnt", rise_cnt, PULSE ? 1 : 0);
        chk_int("s1_fall_cnt", fall_cnt, 0);

        // Scenario 2: 3-cycle high glitch on dout = 0 is rejected
        apply_reset(1'b0, 2);
        repeat (4) cycle(1'b0);
        clear_obs();
        repeat (3) cycle(1'b1);
        repeat (8) cycle(1'b0);
        chk("s2_busy_seen", busy_seen != 0, 1'b1);
        chk("s2_busy_end", busy, 1'b0);
        chk_int("s2_dout_changes", dout_changes, 0);
        chk_int("s2_rise_cnt", rise_cnt, 0);

        // Scenario 3: from dout = 1, din held low -> fall on 6th edge
        repeat (8) cycle(1'b1);
        chk("s3_pre_dout", dout, 1'b1);
        clear_obs();
        for (int k = 1; k <= 7; k++) begin
            cycle(1'b0);
            if (k == 5) chk("s3_dout_e5", dout, 1'b1);
            if (k == 6) begin
                chk("s3_dout_e6", dout, 1'b0);
                chk("s3_fall_e6", fall, PULSE);
            end
            if (k == 7) chk("s3_fall_e7", fall, 1'b0);
        end
        chk_int("s3_rise_cnt", rise_cnt, 0);
        chk_int("s3_fall_cnt", fall_cnt, PULSE ? 1 : 0);

        // Scenario 4: reset mid-qualification (cnt = 2) discards the count
        repeat (4) cycle(1'b0);
        repeat (4) cycle(1'b1);
        chk("s4_busy_before", busy, 1'b1);
        apply_reset(1'b1, 2);
        din = 1'b0;
        repeat (10) cycle(1'b0);
        chk_int("s4_busy_seen", busy_seen, 0);
        chk_int("s4_rise_cnt", rise_cnt, 0);
        chk_int("s4_fall_cnt", fall_cnt, 0);
        chk_int("s4_dout_changes", dout_changes, 0);

        // Scenario 5: toggle every 2 cycles, 10 segments, then hold 1
        clear_obs();
        for (int t = 0; t < 10; t++) begin
            repeat (2) cycle((t % 2) == 0);
        end
        chk_int("s5_toggle_changes", dout_changes, 0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1);
            if (k == 5) chk("s5_dout_e5", dout, 1'b0);
            if (k == 6) chk("s5_dout_e6", dout, 1'b1);
        end
        chk_int("s5_dout_changes", dout_changes, 1);
        chk_int("s5_rise_cnt", rise_cnt, PULSE ? 1 : 0);
        chk_int("s5_fall_cnt", fall_cnt, 0);

        // Randomized runs of random level and length against the model
        clear_obs();
        for (int r = 0; r < 80; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            repeat (len) begin
                cycle(lvl);
                chk("rand_no_both", rise & fall, 1'b0);
            end
            if ($urandom_range(0, 39) == 0) apply_reset(1'($urandom_range(0, 1)), 1);
        end
        if (!PULSE) begin
            chk_int("rand_rise_off", rise_cnt, 0);
            chk_int("rand_fall_off", fall_cnt, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 16, giving the consecutive synchronized samples needed to accept a new level (legal range 2..65535).
REQ-002 The block SHALL have derived localparam CNT_W = $clog2(STABLE_CYCLES+1), giving the counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single 50 MHz clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port din, input, 1 bit: raw asynchronous switch/button level.
REQ-006 The block SHALL have port dout, output, 1 bit: debounced level, intended to drive the D input of the downstream d_flip_flop stage.
REQ-007 The block SHALL have port rise, output, 1 bit: one-cycle pulse when dout goes 0->1.
REQ-008 The block SHALL have port fall, output, 1 bit: one-cycle pulse when dout goes 1->0.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-010 din SHALL pass through a two-flop synchronizer producing din_s, which lags din by 2 clk edges.
REQ-011 The FSM SHALL have two states: STABLE and COUNT.
REQ-012 In STABLE with din_s == dout, the FSM SHALL hold and keep cnt = 0.
REQ-013 In STABLE with din_s != dout, the FSM SHALL go to COUNT with cnt = 1.
REQ-014 In COUNT with din_s == dout, the FSM SHALL return to STABLE, clear cnt to 0 and leave dout unchanged (glitch rejected).
REQ-015 In COUNT with din_s != dout and cnt == STABLE_CYCLES-1, the FSM SHALL set dout <= din_s, clear cnt to 0 and go to STABLE.
REQ-016 In COUNT with din_s != dout and cnt < STABLE_CYCLES-1, the FSM SHALL increment cnt by 1.
REQ-017 cnt SHALL never exceed STABLE_CYCLES-1, and no wrap-around SHALL occur.
REQ-018 dout SHALL change exactly STABLE_CYCLES+2 rising edges after a clean din step that is setup-valid before the first edge.
REQ-019 rise and fall SHALL be registered on the same edge that updates dout, each high for exactly one cycle, and never both high.
REQ-020 busy SHALL be high exactly when the state is COUNT.
REQ-021 A din_s mismatch lasting fewer than STABLE_CYCLES consecutive samples SHALL produce no dout change and no pulse.

Reset
REQ-022 While rst = 1, the block SHALL immediately hold the synchronizer flops = 0, dout = 0, cnt = 0, state = STABLE, rise = fall = busy = 0.
REQ-023 Reset mid-qualification SHALL discard the partial count, with no pulse asserted on or after deassertion.
REQ-024 After rst deasserts, operation SHALL resume on the first rising edge; din = 1 at release SHALL be treated as a normal 0->1 change.

Configuration
REQ-025 The macro SWITCH_DEBOUNCER_EDGE_PULSE_EN SHALL control the edge-pulse logic: when defined, rise/fall SHALL be generated per REQ-019.
REQ-026 When SWITCH_DEBOUNCER_EDGE_PULSE_EN is undefined, rise and fall SHALL remain as ports tied constant 0, with no pulse registers synthesized, and dout/busy behaviour SHALL be unchanged.

Structure
REQ-027 A shared package debounce_pkg SHALL hold the state encodings (ST_STABLE = 1'b0, ST_COUNT = 1'b1) and the default STABLE_CYCLES constant.
REQ-028 The synchronizer SHALL be a separate sub-module, sync_2ff (ports clk, rst, d, q), reusable by other stages.
REQ-029 All state SHALL live in a single clk domain, with no latches and no derived clocks.

Verification (bench uses STABLE_CYCLES = 4, 20 ns period)
REQ-030 Scenario 1: din = 1 during reset -> dout = 0, busy = 0; after release, dout = 1 on the 6th rising edge and rise is high for that single cycle.
REQ-031 Scenario 2: dout = 0, din high for 3 cycles then low -> busy rises then falls, dout stays 0, and rise stays 0.
REQ-032 Scenario 3: dout = 1, din driven low and held -> dout = 0 on the 6th edge, fall pulses for 1 cycle, and rise stays 0.
REQ-033 Scenario 4: dout = 0, rst asserted with cnt = 2 and din = 1 -> all outputs go 0 asynchronously; release with din = 0 -> no pulse, and busy stays 0.
REQ-034 Scenario 5: din toggled every 2 cycles 10 times, then held 1 -> exactly one 0->1 dout change, 6 edges after settling, with exactly one rise.
REQ-035 Scenario 6: Scenario 1 rerun with SWITCH_DEBOUNCER_EDGE_PULSE_EN undefined -> identical dout/busy timing, and rise = fall = 0 throughout.
